// File: rtl/btn_debounce_repeat.sv
// Push-button front end: two-flop synchroniser, debounce counter, registered
// press/release pulses and an optional hold-to-auto-repeat pulse stream.
// Optional feature macro: BTN_RPT_EN (defined = build repeat FSM; undefined =
// btn_rpt mirrors btn_pe, one pulse per press).
module btn_debounce_repeat #(
  parameter int unsigned DEBOUNCE_CYC = 1250000,
  parameter int unsigned HOLD_CYC     = 62500000,
  parameter int unsigned REPEAT_CYC   = 12500000
) (
  input  logic clk,
  input  logic reset_p,
  input  logic btn,
  output logic btn_level,
  output logic btn_pe,
  output logic btn_ne,
  output logic btn_rpt
);

  localparam int unsigned DbW = $clog2(DEBOUNCE_CYC + 1);

  logic           s1_q, s2_q;
  logic [DbW-1:0] db_cnt_q, db_cnt_d;
  logic           level_q, level_d;
  logic           pe_q, pe_d;
  logic           ne_q, ne_d;

  // Synchroniser, debounce state and edge pulse registers.
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      db_cnt_q <= '0;
      level_q  <= 1'b0;
      pe_q     <= 1'b0;
      ne_q     <= 1'b0;
    end else begin
      s1_q     <= btn;
      s2_q     <= s1_q;
      db_cnt_q <= db_cnt_d;
      level_q  <= level_d;
      pe_q     <= pe_d;
      ne_q     <= ne_d;
    end
  end

  // Accept a new level after DEBOUNCE_CYC consecutive cycles of disagreement.
  always_comb begin
    level_d  = level_q;
    db_cnt_d = '0;
    if (s2_q != level_q) begin
      if (db_cnt_q == DbW'(DEBOUNCE_CYC - 1)) begin
        level_d  = s2_q;
        db_cnt_d = '0;
      end else begin
        db_cnt_d = db_cnt_q + DbW'(1);
      end
    end
    // Pulses are registered alongside the level so they coincide with it.
    pe_d = level_d & ~level_q;
    ne_d = ~level_d & level_q;
  end

  assign btn_level = level_q;
  assign btn_pe    = pe_q;
  assign btn_ne    = ne_q;

`ifdef BTN_RPT_EN
  localparam int unsigned RpMax = (HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC;
  localparam int unsigned RpW   = $clog2(RpMax + 1);

  typedef enum logic [1:0] {
    StIdle,
    StHold,
    StRepeat
  } rpt_state_e;

  rpt_state_e     state_q, state_d;
  logic [RpW-1:0] rp_cnt_q, rp_cnt_d;
  logic           rpt_q, rpt_d;

  // Repeat FSM state, counter and pulse register.
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      state_q  <= StIdle;
      rp_cnt_q <= '0;
      rpt_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rp_cnt_q <= rp_cnt_d;
      rpt_q    <= rpt_d;
    end
  end

  // Press pulse, first repeat after HOLD_CYC, then one every REPEAT_CYC.
  // Decisions use the next-state level/pulse so btn_rpt lines up with btn_pe
  // and release wins over a coincident terminal count.
  always_comb begin
    state_d  = state_q;
    rp_cnt_d = rp_cnt_q;
    rpt_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        rp_cnt_d = '0;
        if (pe_d) begin
          state_d = StHold;
          rpt_d   = 1'b1;
        end
      end
      StHold: begin
        if (!level_d) begin
          state_d  = StIdle;
          rp_cnt_d = '0;
        end else if (rp_cnt_q == RpW'(HOLD_CYC - 1)) begin
          state_d  = StRepeat;
          rp_cnt_d = '0;
          rpt_d    = 1'b1;
        end else begin
          rp_cnt_d = rp_cnt_q + RpW'(1);
        end
      end
      StRepeat: begin
        if (!level_d) begin
          state_d  = StIdle;
          rp_cnt_d = '0;
        end else if (rp_cnt_q == RpW'(REPEAT_CYC - 1)) begin
          rp_cnt_d = '0;
          rpt_d    = 1'b1;
        end else begin
          rp_cnt_d = rp_cnt_q + RpW'(1);
        end
      end
      default: begin
        state_d  = StIdle;
        rp_cnt_d = '0;
      end
    endcase
  end

  assign btn_rpt = rpt_q;
`else
  assign btn_rpt = pe_q;
`endif

endmodule

// File: tb/tb_btn_debounce_repeat.sv
// Directed bench for btn_debounce_repeat: expected pulse events are queued
// with their cycle numbers when stimulus is driven, and a negedge monitor
// pops and compares them against every output each cycle.
module tb_btn_debounce_repeat;

  localparam int unsigned DB   = 4;
  localparam int unsigned HOLD = 20;
  localparam int unsigned RPT  = 5;

  localparam logic [2:0] MPE = 3'b100;
  localparam logic [2:0] MNE = 3'b010;
  localparam logic [2:0] MRP = 3'b001;

  logic clk = 1'b0;
  logic reset_p;
  logic btn;
  logic btn_level, btn_pe, btn_ne, btn_rpt;

  btn_debounce_repeat #(
    .DEBOUNCE_CYC(DB),
    .HOLD_CYC    (HOLD),
    .REPEAT_CYC  (RPT)
  ) dut (
    .clk      (clk),
    .reset_p  (reset_p),
    .btn      (btn),
    .btn_level(btn_level),
    .btn_pe   (btn_pe),
    .btn_ne   (btn_ne),
    .btn_rpt  (btn_rpt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         t;
    logic [2:0] m;
  } ev_t;

  ev_t  sb[$];
  int   nchk = 0;
  int   nerr = 0;
  int   rpt_seen = 0;
  logic lvl_exp;
  logic [2:0] exp_m, obs_m;

  task automatic push(input int t, input logic [2:0] m);
    ev_t e;
    e.t = t;
    e.m = m;
    sb.push_back(e);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: pulses {pe,ne,rpt} and level compared every cycle.
  always @(negedge clk) begin
    if (reset_p) begin
      lvl_exp = 1'b0;
    end else begin
      exp_m = 3'b000;
      if (sb.size() > 0 && sb[0].t == cyc) begin
        exp_m = sb[0].m;
        void'(sb.pop_front());
      end
      if (exp_m[2]) lvl_exp = 1'b1;
      if (exp_m[1]) lvl_exp = 1'b0;
      obs_m = {btn_pe, btn_ne, btn_rpt};
      if (btn_rpt === 1'b1) rpt_seen++;
      nchk++;
      assert (obs_m === exp_m) else begin
        nerr++;
        $error("FAIL pulses cyc=%0d observed pe/ne/rpt=%b expected=%b", cyc, obs_m, exp_m);
      end
      nchk++;
      assert (btn_level === lvl_exp) else begin
        nerr++;
        $error("FAIL level cyc=%0d observed=%b expected=%b", cyc, btn_level, lvl_exp);
      end
    end
  end

  int t0, p, ne_t, r, rs;
  int exp_cnt;

  initial begin
    reset_p = 1'b1;
    btn     = 1'b0;
    #1;
    nchk++;
    assert ({btn_level, btn_pe, btn_ne, btn_rpt} === 4'b0000) else begin
      nerr++;
      $error("FAIL reset_state observed=%b expected=0000", {btn_level, btn_pe, btn_ne, btn_rpt});
    end
    wait_cyc(3);
    reset_p = 1'b0;
    wait_cyc(3);

    // Clean press held 15 cycles.
    t0 = cyc;
    btn = 1'b1;
    push(t0 + 6, MPE | MRP);
    wait_cyc(15);
    btn = 1'b0;
    push(cyc + 6, MNE);
    wait_cyc(12);

    // Bounce: three short high/low pairs, then stable high.
    for (int i = 0; i < 3; i++) begin
      btn = 1'b1;
      wait_cyc(2);
      btn = 1'b0;
      wait_cyc(2);
    end
    btn = 1'b1;
    push(cyc + 6, MPE | MRP);
    wait_cyc(16);
    btn = 1'b0;
    push(cyc + 6, MNE);
    wait_cyc(12);

    // Long hold: release 60 cycles after the press pulse.
    rs = rpt_seen;
    t0 = cyc;
    btn = 1'b1;
    p = t0 + 6;
    ne_t = p + 66;
    push(p, MPE | MRP);
`ifdef BTN_RPT_EN
    for (int t = p + int'(HOLD); t < ne_t; t += int'(RPT)) push(t, MRP);
    exp_cnt = 1 + 1 + (66 - int'(HOLD) - 1) / int'(RPT);
`else
    exp_cnt = 1;
`endif
    wait_cyc(66);
    btn = 1'b0;
    push(ne_t, MNE);
    wait_cyc(12);
    nchk++;
    assert (rpt_seen - rs === exp_cnt) else begin
      nerr++;
      $error("FAIL long_hold_rpt_count observed=%0d expected=%0d", rpt_seen - rs, exp_cnt);
    end

    // Release while still in the hold phase.
    rs = rpt_seen;
    t0 = cyc;
    btn = 1'b1;
    push(t0 + 6, MPE | MRP);
    wait_cyc(16);
    btn = 1'b0;
    push(cyc + 6, MNE);
    wait_cyc(12);
    nchk++;
    assert (rpt_seen - rs === 1) else begin
      nerr++;
      $error("FAIL hold_release_rpt_count observed=%0d expected=1", rpt_seen - rs);
    end

    // Reset during auto-repeat with the button still held.
    t0 = cyc;
    btn = 1'b1;
    p = t0 + 6;
    push(p, MPE | MRP);
`ifdef BTN_RPT_EN
    push(p + 20, MRP);
    push(p + 25, MRP);
`endif
    wait_cyc(33);
    nchk++;
    assert (btn_level === 1'b1) else begin
      nerr++;
      $error("FAIL pre_reset_level observed=%b expected=1", btn_level);
    end
    #2;
    reset_p = 1'b1;
    #1;
    nchk++;
    assert ({btn_level, btn_pe, btn_ne, btn_rpt} === 4'b0000) else begin
      nerr++;
      $error("FAIL async_reset observed=%b expected=0000", {btn_level, btn_pe, btn_ne, btn_rpt});
    end
    sb.delete();
    wait_cyc(3);
    #2;
    reset_p = 1'b0;
    r = cyc;
    push(r + 6, MPE | MRP);
    wait_cyc(16);
    btn = 1'b0;
    push(cyc + 6, MNE);
    wait_cyc(12);

    nchk++;
    assert (sb.size() === 0) else begin
      nerr++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
